// File: rtl/stroke_ctrl_pkg.sv
// Shared types and constants for the stroke session controller: FSM states,
// the blank 7-segment pattern and the default canvas geometry.
package stroke_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DRAW,
      ST_GAP,
      ST_LATCH
   } state_t;

   localparam logic [6:0]  BLANK_HEX        = 7'h7F;
   localparam int unsigned CANVAS_W_DEFAULT = 320;
   localparam int unsigned CANVAS_H_DEFAULT = 240;
   localparam logic [3:0]  STROKE_MAX       = 4'd15;

   // Stroke counter increment that sticks at its maximum instead of wrapping.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == STROKE_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/stroke_gap_timer.sv
// Terminal-count cycle counter: counts enabled cycles from zero and flags the
// cycle in which the count equals tc_i. A synchronous clear restarts it.
module stroke_gap_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] tc_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign done_o = (count_q == tc_i);

   // Holding at the terminal value keeps done_o stable if the owner is late to clear.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && !done_o) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/stroke_session_ctrl.sv
// Mouse-driven handwriting session controller: clears the classifier, gates its
// enable while the pen is down, and latches its digit once the pen settles.
module stroke_session_ctrl
   import stroke_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 25_000_000,
   parameter int unsigned CLR_CYCLES    = 2,
   parameter int unsigned CANVAS_W      = CANVAS_W_DEFAULT,
   parameter int unsigned CANVAS_H      = CANVAS_H_DEFAULT
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       left_btn,
   input  logic       right_btn,
   input  logic [8:0] mouse_x,
   input  logic [7:0] mouse_y,
   input  logic [6:0] clf_hex,
   output logic       clf_reset,
   output logic       draw_en,
   output logic [6:0] result_hex,
   output logic       result_valid,
   output logic       busy,
   output logic [3:0] stroke_cnt
);

   localparam int unsigned GAP_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(SETTLE_CYCLES - 1);
   localparam logic [CLR_W-1:0] CLR_TC = CLR_W'(CLR_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] stroke_cnt_q, stroke_cnt_d;
   logic [6:0] result_hex_q, result_hex_d;
   logic       result_valid_q, result_valid_d;
   logic       clf_reset_q, clf_reset_d;

   logic in_bounds;
   logic pen;
   logic clr_done, gap_done;
   logic clr_tmr_clr, gap_tmr_clr;

   assign in_bounds = (32'(mouse_x) < CANVAS_W) && (32'(mouse_y) < CANVAS_H);
   assign pen       = left_btn && in_bounds;

   // Each timer restarts whenever its state is not being continued this cycle.
   assign clr_tmr_clr = right_btn || (state_q != ST_CLEAR) || clr_done;
   assign gap_tmr_clr = right_btn || (state_q != ST_GAP) || pen || gap_done;

   stroke_gap_timer #(
      .WIDTH (CLR_W)
   ) u_clr_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (clr_tmr_clr),
      .en_i   (state_q == ST_CLEAR),
      .tc_i   (CLR_TC),
      .done_o (clr_done)
   );

   stroke_gap_timer #(
      .WIDTH (GAP_W)
   ) u_gap_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (gap_tmr_clr),
      .en_i   (state_q == ST_GAP),
      .tc_i   (GAP_TC),
      .done_o (gap_done)
   );

   always_comb begin
      state_d        = state_q;
      stroke_cnt_d   = stroke_cnt_q;
      result_hex_d   = result_hex_q;
      result_valid_d = 1'b0;
      if (right_btn) begin
         state_d      = ST_CLEAR;
         stroke_cnt_d = 4'd0;
         result_hex_d = BLANK_HEX;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pen) begin
                  state_d = ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (clr_done) begin
                  if (pen) begin
                     state_d      = ST_DRAW;
                     stroke_cnt_d = 4'd1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DRAW: begin
               // Leaving the canvas with the button held is not a pen lift.
               if (!left_btn) begin
                  state_d = ST_GAP;
               end
            end
            ST_GAP: begin
               if (pen) begin
                  state_d      = ST_DRAW;
                  stroke_cnt_d = sat_inc4(stroke_cnt_q);
               end else if (gap_done) begin
                  state_d = ST_LATCH;
               end
            end
            ST_LATCH: begin
               state_d        = ST_IDLE;
               result_hex_d   = clf_hex;
               result_valid_d = 1'b1;
            end
            default: begin
               state_d = ST_CLEAR;
            end
         endcase
      end
      clf_reset_d = (state_d == ST_CLEAR);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_CLEAR;
         stroke_cnt_q   <= 4'd0;
         result_hex_q   <= BLANK_HEX;
         result_valid_q <= 1'b0;
         clf_reset_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         stroke_cnt_q   <= stroke_cnt_d;
         result_hex_q   <= result_hex_d;
         result_valid_q <= result_valid_d;
         clf_reset_q    <= clf_reset_d;
      end
   end

   assign draw_en      = (state_q == ST_DRAW) && pen;
   assign clf_reset    = clf_reset_q;
   assign result_hex   = result_hex_q;
   assign result_valid = result_valid_q;
   assign busy         = (state_q != ST_IDLE);
   assign stroke_cnt   = stroke_cnt_q;

endmodule

// File: tb/tb_stroke_session_ctrl.sv
// Scenario bench for stroke_session_ctrl with short settle/clear times; the
// expected timing and values come from the session rules, not the FSM encoding.
module tb_stroke_session_ctrl;

   localparam int SETTLE   = 8;
   localparam int CLR      = 2;
   localparam int CANVAS_W = 320;
   localparam int CANVAS_H = 240;

   logic       clk = 1'b0;
   logic       resetn;
   logic       left_btn;
   logic       right_btn;
   logic [8:0] mouse_x;
   logic [7:0] mouse_y;
   logic [6:0] clf_hex;
   logic       clf_reset;
   logic       draw_en;
   logic [6:0] result_hex;
   logic       result_valid;
   logic       busy;
   logic [3:0] stroke_cnt;

   int n_checks     = 0;
   int n_fail       = 0;
   int valid_pulses = 0;

   always #5 clk = ~clk;

   stroke_session_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .CLR_CYCLES    (CLR),
      .CANVAS_W      (CANVAS_W),
      .CANVAS_H      (CANVAS_H)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .left_btn     (left_btn),
      .right_btn    (right_btn),
      .mouse_x      (mouse_x),
      .mouse_y      (mouse_y),
      .clf_hex      (clf_hex),
      .clf_reset    (clf_reset),
      .draw_en      (draw_en),
      .result_hex   (result_hex),
      .result_valid (result_valid),
      .busy         (busy),
      .stroke_cnt   (stroke_cnt)
   );

   // Advance n rising edges; outputs are observed 1 time unit after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (result_valid === 1'b1) valid_pulses++;
      end
   endtask

   // Edges until result_valid is seen, bounded; returns -1 on timeout.
   task automatic wait_valid(output int edges);
      edges = -1;
      for (int i = 1; i <= 40; i++) begin
         step(1);
         if (result_valid === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
      mouse_x = 9'd0; mouse_y = 8'd0; clf_hex = 7'h7F;
      step(2);
      n_checks++; if (clf_reset !== 1'b1) begin n_fail++; $display("FAIL reset_clf_reset: got %b want 1", clf_reset); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_checks++; if (result_hex !== 7'h7F) begin n_fail++; $display("FAIL reset_hex: got %h want 7f", result_hex); end
      n_checks++; if (stroke_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_strokes: got %0d want 0", stroke_cnt); end
      resetn = 1'b1;
      step(CLR - 1);
      n_checks++; if (clf_reset !== 1'b1) begin n_fail++; $display("FAIL release_clear_hold: got %b want 1", clf_reset); end
      step(1);
      n_checks++; if (clf_reset !== 1'b0) begin n_fail++; $display("FAIL release_clear_end: got %b want 0", clf_reset); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_idle: got busy=%b want 0", busy); end
      n_checks++; if (result_hex !== 7'h7F || draw_en !== 1'b0 || result_valid !== 1'b0) begin
         n_fail++; $display("FAIL release_outputs: got hex=%h en=%b valid=%b want 7f 0 0", result_hex, draw_en, result_valid);
      end
      $display("reset: clear lasted %0d cycles after release, busy=%b", CLR, busy);
   endtask

   // One digit of n strokes from IDLE; gap_fixed>0 forces every gap length.
   task automatic run_strokes(input int n, input int gap_fixed, input string tag);
      int         len, g, edges, p0, exp_cnt;
      logic [6:0] hex;
      hex      = 7'($urandom_range(0, 126));
      mouse_x  = 9'($urandom_range(0, CANVAS_W - 1));
      mouse_y  = 8'($urandom_range(0, CANVAS_H - 1));
      clf_hex  = 7'($urandom);
      left_btn = 1'b1;
      p0       = valid_pulses;
      step(CLR);
      n_checks++; if (clf_reset !== 1'b1 || draw_en !== 1'b0) begin
         n_fail++; $display("FAIL %s_clear: got clf_reset=%b draw_en=%b want 1 0", tag, clf_reset, draw_en);
      end
      step(1);
      n_checks++; if (draw_en !== 1'b1 || stroke_cnt !== 4'd1) begin
         n_fail++; $display("FAIL %s_first_stroke: got draw_en=%b cnt=%0d want 1 1", tag, draw_en, stroke_cnt);
      end
      len = $urandom_range(1, 20);
      step(len);
      for (int s = 2; s <= n; s++) begin
         g = (gap_fixed > 0) ? gap_fixed : $urandom_range(1, SETTLE - 1);
         left_btn = 1'b0;
         step(g);
         n_checks++; if (draw_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s_gap: got draw_en=%b busy=%b want 0 1", tag, draw_en, busy);
         end
         left_btn = 1'b1;
         step(1);
         exp_cnt = (s > 15) ? 15 : s;
         n_checks++; if (stroke_cnt !== 4'(exp_cnt) || draw_en !== 1'b1) begin
            n_fail++; $display("FAIL %s_restroke: got cnt=%0d en=%b want %0d 1", tag, stroke_cnt, draw_en, exp_cnt);
         end
         len = $urandom_range(1, 6);
         step(len);
      end
      n_checks++; if (valid_pulses !== p0) begin
         n_fail++; $display("FAIL %s_early_latch: got %0d pulses want 0", tag, valid_pulses - p0);
      end
      left_btn = 1'b0;
      clf_hex  = hex;
      wait_valid(edges);
      exp_cnt = (n > 15) ? 15 : n;
      n_checks++; if (edges !== SETTLE + 2) begin
         n_fail++; $display("FAIL %s_latch_time: got %0d edges want %0d", tag, edges, SETTLE + 2);
      end
      n_checks++; if (result_hex !== hex) begin
         n_fail++; $display("FAIL %s_latch_hex: got %h want %h", tag, result_hex, hex);
      end
      n_checks++; if (stroke_cnt !== 4'(exp_cnt) || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s_after_latch: got cnt=%0d busy=%b want %0d 0", tag, stroke_cnt, busy, exp_cnt);
      end
      step(1);
      n_checks++; if (result_valid !== 1'b0 || valid_pulses - p0 !== 1) begin
         n_fail++; $display("FAIL %s_valid_width: got valid=%b pulses=%0d want 0 1", tag, result_valid, valid_pulses - p0);
      end
      $display("%s: strokes=%0d latched hex=%h after %0d edges", tag, n, result_hex, edges);
   endtask

   task automatic test_single_stroke;
      for (int it = 0; it < 3; it++) run_strokes(1, 0, "single");
   endtask

   task automatic test_multi_stroke;
      run_strokes(2, 5, "two_gap5");
      for (int it = 0; it < 3; it++) run_strokes($urandom_range(2, 5), 0, "multi");
   endtask

   task automatic test_saturation;
      run_strokes(17, 1, "saturate");
   endtask

   task automatic test_right_in_gap;
      int p0, h;
      mouse_x = 9'd10; mouse_y = 8'd10; left_btn = 1'b1;
      step(CLR + 1 + 5);
      p0 = valid_pulses;
      left_btn = 1'b0;
      step(5);
      right_btn = 1'b1;
      step(1);
      n_checks++; if (result_hex !== 7'h7F || stroke_cnt !== 4'd0 || clf_reset !== 1'b1) begin
         n_fail++; $display("FAIL right_gap_clear: got hex=%h cnt=%0d clf_reset=%b want 7f 0 1", result_hex, stroke_cnt, clf_reset);
      end
      h = $urandom_range(1, 3);
      step(h);
      n_checks++; if (clf_reset !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL right_held: got clf_reset=%b busy=%b want 1 1", clf_reset, busy);
      end
      right_btn = 1'b0;
      step(CLR - 1);
      n_checks++; if (clf_reset !== 1'b1) begin n_fail++; $display("FAIL right_restart_count: got %b want 1", clf_reset); end
      step(1);
      n_checks++; if (clf_reset !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL right_to_idle: got clf_reset=%b busy=%b want 0 0", clf_reset, busy);
      end
      step(SETTLE + 4);
      n_checks++; if (valid_pulses !== p0 || result_hex !== 7'h7F) begin
         n_fail++; $display("FAIL right_gap_no_latch: got pulses=%0d hex=%h want 0 7f", valid_pulses - p0, result_hex);
      end
      $display("right_in_gap: held %0d extra cycles, hex=%h", h, result_hex);
   endtask

   task automatic test_right_in_latch;
      int p0;
      mouse_x = 9'd50; mouse_y = 8'd60; left_btn = 1'b1;
      step(CLR + 1 + 3);
      p0 = valid_pulses;
      left_btn = 1'b0;
      clf_hex  = 7'h12;
      step(SETTLE + 1);
      n_checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL latch_reached: got valid=%b busy=%b want 0 1", result_valid, busy);
      end
      right_btn = 1'b1;
      step(1);
      right_btn = 1'b0;
      step(CLR + SETTLE);
      n_checks++; if (valid_pulses !== p0 || result_hex !== 7'h7F) begin
         n_fail++; $display("FAIL right_latch_suppress: got pulses=%0d hex=%h want 0 7f", valid_pulses - p0, result_hex);
      end
      $display("right_in_latch: pulses=%0d hex=%h", valid_pulses - p0, result_hex);
   endtask

   task automatic test_bounds;
      int edges;
      mouse_x = 9'd400; mouse_y = 8'd10; left_btn = 1'b1;
      step(5);
      n_checks++; if (busy !== 1'b0 || clf_reset !== 1'b0) begin
         n_fail++; $display("FAIL oob_press: got busy=%b clf_reset=%b want 0 0", busy, clf_reset);
      end
      mouse_x = 9'd10;
      step(CLR + 1);
      n_checks++; if (draw_en !== 1'b1) begin n_fail++; $display("FAIL bounds_start: got %b want 1", draw_en); end
      mouse_x = 9'd319; #1;
      n_checks++; if (draw_en !== 1'b1) begin n_fail++; $display("FAIL bounds_x319: got %b want 1", draw_en); end
      mouse_x = 9'd320; #1;
      n_checks++; if (draw_en !== 1'b0) begin n_fail++; $display("FAIL bounds_x320: got %b want 0", draw_en); end
      step(3);
      mouse_x = 9'd330;
      step(2);
      n_checks++; if (draw_en !== 1'b0 || busy !== 1'b1 || clf_reset !== 1'b0) begin
         n_fail++; $display("FAIL bounds_x330: got en=%b busy=%b clf_reset=%b want 0 1 0", draw_en, busy, clf_reset);
      end
      mouse_x = 9'd300; #1;
      n_checks++; if (draw_en !== 1'b1 || stroke_cnt !== 4'd1) begin
         n_fail++; $display("FAIL bounds_x300: got en=%b cnt=%0d want 1 1", draw_en, stroke_cnt);
      end
      mouse_y = 8'd240; #1;
      n_checks++; if (draw_en !== 1'b0) begin n_fail++; $display("FAIL bounds_y240: got %b want 0", draw_en); end
      mouse_y = 8'd239; #1;
      n_checks++; if (draw_en !== 1'b1) begin n_fail++; $display("FAIL bounds_y239: got %b want 1", draw_en); end
      step(2);
      left_btn = 1'b0;
      clf_hex  = 7'b1111001;
      wait_valid(edges);
      n_checks++; if (edges !== SETTLE + 2 || result_hex !== 7'b1111001) begin
         n_fail++; $display("FAIL bounds_latch: got edges=%0d hex=%h want %0d 79", edges, result_hex, SETTLE + 2);
      end
      step(1);
      $display("bounds: dragged off canvas and back, latched hex=%h", result_hex);
   endtask

   task automatic test_async_reset;
      mouse_x = 9'd10; mouse_y = 8'd10; left_btn = 1'b1;
      step(CLR + 1 + 2);
      #2;
      resetn = 1'b0;
      #1;
      n_checks++; if (clf_reset !== 1'b1 || draw_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL async_ctrl: got clf_reset=%b en=%b busy=%b want 1 0 1", clf_reset, draw_en, busy);
      end
      n_checks++; if (result_hex !== 7'h7F || result_valid !== 1'b0 || stroke_cnt !== 4'd0) begin
         n_fail++; $display("FAIL async_data: got hex=%h valid=%b cnt=%0d want 7f 0 0", result_hex, result_valid, stroke_cnt);
      end
      step(1);
      resetn = 1'b1;
      step(CLR - 1);
      n_checks++; if (clf_reset !== 1'b1 || draw_en !== 1'b0) begin
         n_fail++; $display("FAIL async_release_clear: got clf_reset=%b en=%b want 1 0", clf_reset, draw_en);
      end
      step(1);
      n_checks++; if (draw_en !== 1'b1 || stroke_cnt !== 4'd1 || clf_reset !== 1'b0) begin
         n_fail++; $display("FAIL async_release_draw: got en=%b cnt=%0d clf_reset=%b want 1 1 0", draw_en, stroke_cnt, clf_reset);
      end
      left_btn = 1'b0;
      step(SETTLE + 3);
      $display("async_reset: outputs forced without a clock edge, resumed drawing after clear");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_stroke();
      test_multi_stroke();
      test_saturation();
      test_right_in_gap();
      test_right_in_latch();
      test_bounds();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
